// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequencer slice.
//   state_t       : sequencer states (IDLE/LOAD/RUN/DONE)
//   MODE_ONESHOT  : stop in DONE after the first expiry
//   MODE_PERIODIC : keep running, re-arming after every expiry
//   CNT_W_DEFAULT : default counter width, must match the counter instance
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int CNT_W_DEFAULT = 17;

endpackage : timer_pkg

// File: rtl/timer_ctrl_prescaler.sv
// Clock prescaler for the timer sequencer.
// Ports:
//   clk   : system clock
//   clr   : synchronous active-high reset, divider to 0
//   load  : hold the divider at 0 (used outside RUN so each run starts aligned)
//   en    : advance the divider
//   presc : divisor minus 1; tick fires when the divider reaches it
//   tick  : one-cycle strobe every presc+1 enabled cycles
module timer_prescaler #(
    parameter int PRS_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [PRS_W-1:0] presc,
    output logic             tick
);

    logic [PRS_W-1:0] div_reg;

    assign tick = en && (div_reg == presc);

    always_ff @(posedge clk) begin
        if (clr || load) begin
            div_reg <= '0;
        end else if (en) begin
            // Wrap on tick so the divider never exceeds presc.
            div_reg <= tick ? '0 : div_reg + {{(PRS_W-1){1'b0}}, 1'b1};
        end
    end

endmodule : timer_prescaler

// File: rtl/timer_ctrl.sv
// Sequencer for an external CNT_W-bit counter: owns the counter's en/clr,
// divides clk by presc+1, detects expiry at a programmable period and runs
// one-shot or periodic. Raises a sticky irq per expiry.
// Ports:
//   clk, clr           : clock, synchronous active-high reset
//   start, stop        : command pulses (stop wins when both asserted)
//   mode/period/presc  : configuration, latched when start is accepted
//   irq_ack            : clears irq (a simultaneous expiry keeps it set)
//   cnt_out, cnt_tcc   : counter value and terminal-count flag
//   cnt_en, cnt_clr    : counter increment / synchronous clear (clr wins)
//   busy               : in LOAD or RUN
//   irq, err           : sticky expiry flag, sticky tcc-in-RUN fault
//   expire_cnt         : saturating count of expiries since reset
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int PRS_W = 8,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [PRS_W-1:0] presc,
    input  logic             irq_ack,
    input  logic [CNT_W-1:0] cnt_out,
    input  logic             cnt_tcc,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             irq,
    output logic             err,
    output logic [EXP_W-1:0] expire_cnt
);

    state_t           state_reg, state_next;
    logic             mode_reg;
    logic [CNT_W-1:0] period_reg;
    logic [PRS_W-1:0] presc_reg;
    logic             irq_reg;
    logic             err_reg;
    logic [EXP_W-1:0] expire_cnt_reg;

    logic             tick;
    logic             expiry;
    logic             fault;
    logic             latch_cfg;
    logic             cnt_en_next;
    logic             cnt_clr_next;

    timer_prescaler #(
        .PRS_W (PRS_W)
    ) u_prescaler (
        .clk   (clk),
        .clr   (clr),
        .load  (state_reg != RUN),
        .en    (state_reg == RUN),
        .presc (presc_reg),
        .tick  (tick)
    );

    always_comb begin
        state_next   = state_reg;
        cnt_en_next  = 1'b0;
        cnt_clr_next = 1'b0;
        expiry       = 1'b0;
        fault        = 1'b0;
        latch_cfg    = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_clr_next = 1'b1;
                if (start) begin
                    state_next = LOAD;
                    latch_cfg  = 1'b1;
                end
            end
            LOAD: begin
                cnt_clr_next = 1'b1;
                state_next   = RUN;
                if (start) begin
                    state_next = LOAD;
                    latch_cfg  = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    // Restart: re-latch and clear the counter immediately.
                    state_next   = LOAD;
                    latch_cfg    = 1'b1;
                    cnt_clr_next = 1'b1;
                end else if (cnt_tcc) begin
                    // Cannot happen with a latched period <= max; guards a
                    // misbehaving counter from wrapping silently.
                    fault        = 1'b1;
                    cnt_clr_next = 1'b1;
                    state_next   = DONE;
                end else if (tick) begin
                    if (cnt_out == period_reg - {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        // Clearing instead of incrementing makes the next
                        // period start from 0 with no gap cycle.
                        expiry       = 1'b1;
                        cnt_clr_next = 1'b1;
                        state_next   = (mode_reg == MODE_PERIODIC) ? RUN : DONE;
                    end else begin
                        cnt_en_next = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_next = LOAD;
                    latch_cfg  = 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                cnt_clr_next = 1'b1;
            end
        endcase

        // Abort has priority over everything, including a coincident start
        // or expiry; flags are left as they are.
        if (stop) begin
            state_next  = IDLE;
            latch_cfg   = 1'b0;
            expiry      = 1'b0;
            fault       = 1'b0;
            cnt_en_next = 1'b0;
        end

        if (clr) begin
            cnt_en_next  = 1'b0;
            cnt_clr_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg      <= IDLE;
            mode_reg       <= MODE_ONESHOT;
            period_reg     <= {{(CNT_W-1){1'b0}}, 1'b1};
            presc_reg      <= '0;
            irq_reg        <= 1'b0;
            err_reg        <= 1'b0;
            expire_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_cfg) begin
                mode_reg   <= mode;
                // A zero period would never match; treat it as one tick.
                period_reg <= (period == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : period;
                presc_reg  <= presc;
            end
            if (expiry) begin
                irq_reg <= 1'b1;
            end else if (irq_ack) begin
                irq_reg <= 1'b0;
            end
            if (fault) begin
                err_reg <= 1'b1;
            end
            if (expiry && (expire_cnt_reg != {EXP_W{1'b1}})) begin
                expire_cnt_reg <= expire_cnt_reg + {{(EXP_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign cnt_en     = cnt_en_next;
    assign cnt_clr    = cnt_clr_next;
    assign busy       = !clr && ((state_reg == LOAD) || (state_reg == RUN));
    assign irq        = irq_reg;
    assign err        = err_reg;
    assign expire_cnt = expire_cnt_reg;

endmodule : timer_ctrl

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural 17-bit counter attached.
module tb_timer_ctrl;

    localparam int CNT_W = 17;
    localparam int PRS_W = 8;
    localparam int EXP_W = 8;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] period;
    logic [PRS_W-1:0] presc;
    logic             irq_ack;
    logic [CNT_W-1:0] cnt_reg;
    logic             cnt_tcc;
    logic             cnt_en;
    logic             cnt_clr;
    logic             busy;
    logic             irq;
    logic             err;
    logic [EXP_W-1:0] expire_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Counter instance the sequencer drives.
    always_ff @(posedge clk) begin
        if (cnt_clr) begin
            cnt_reg <= '0;
        end else if (cnt_en) begin
            cnt_reg <= cnt_reg + 17'd1;
        end
    end
    assign cnt_tcc = &cnt_reg;

    timer_ctrl #(
        .CNT_W (CNT_W),
        .PRS_W (PRS_W),
        .EXP_W (EXP_W)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .period     (period),
        .presc      (presc),
        .irq_ack    (irq_ack),
        .cnt_out    (cnt_reg),
        .cnt_tcc    (cnt_tcc),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .busy       (busy),
        .irq        (irq),
        .err        (err),
        .expire_cnt (expire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        tests_run++;
        if (obs !== exp_val) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_val);
        end
    endtask

    // Advance one clock; leaves time 1 unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
        step();
    endtask

    // Issue a one-cycle start; returns with the sequencer in LOAD.
    task automatic do_start(input logic m, input logic [CNT_W-1:0] p, input logic [PRS_W-1:0] ps);
        start  = 1'b1;
        mode   = m;
        period = p;
        presc  = ps;
        step();
        start = 1'b0;
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        period = '0; presc = '0; irq_ack = 1'b0;

        // Reset values while clr is held.
        step();
        step();
        $display("[TB] reset");
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_exp", 32'(expire_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(cnt_en), 32'd0);
        check("rst_clr", 32'(cnt_clr), 32'd1);
        check("rst_cnt", 32'(cnt_reg), 32'd0);
        clr = 1'b0;
        step();

        // 1: one-shot, period 5, presc 0.
        $display("[TB] one-shot period=5 presc=0");
        do_start(1'b0, 17'd5, 8'd0);
        check("t1_load_busy", 32'(busy), 32'd1);
        step();
        repeat (4) step();
        check("t1_pre_irq", 32'(irq), 32'd0);
        check("t1_pre_cnt", 32'(cnt_reg), 32'd4);
        step();
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_cnt", 32'(cnt_reg), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_exp", 32'(expire_cnt), 32'd1);
        step();
        check("t1_hold_cnt", 32'(cnt_reg), 32'd0);
        check("t1_hold_busy", 32'(busy), 32'd0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t1_ack", 32'(irq), 32'd0);

        // 2: periodic, period 3, presc 3 -> expiry every 12 cycles.
        $display("[TB] periodic period=3 presc=3");
        do_reset();
        do_start(1'b1, 17'd3, 8'd3);
        step();
        for (int k = 1; k <= 4; k++) begin
            repeat (11) step();
            check("t2_before", 32'(expire_cnt), 32'(k - 1));
            step();
            check("t2_after", 32'(expire_cnt), 32'(k));
            check("t2_irq", 32'(irq), 32'd1);
        end
        check("t2_busy", 32'(busy), 32'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t2_ack", 32'(irq), 32'd0);

        // 3: periodic period 2 presc 0, 300 expiries -> saturation.
        $display("[TB] saturation 300 expiries");
        do_reset();
        do_start(1'b1, 17'd2, 8'd0);
        step();
        repeat (600) step();
        check("t3_sat", 32'(expire_cnt), 32'd255);
        check("t3_irq", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        step();
        check("t3_ack_clear", 32'(irq), 32'd0);
        step();
        irq_ack = 1'b0;
        check("t3_ack_vs_expiry", 32'(irq), 32'd1);
        check("t3_sat_hold", 32'(expire_cnt), 32'd255);

        // 4: stop in RUN at cnt_out = 7; stop+start together.
        $display("[TB] stop in RUN");
        do_reset();
        do_start(1'b1, 17'd20, 8'd0);
        step();
        repeat (7) step();
        check("t4_cnt7", 32'(cnt_reg), 32'd7);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_irq", 32'(irq), 32'd0);
        step();
        check("t4_cnt0", 32'(cnt_reg), 32'd0);
        do_start(1'b1, 17'd20, 8'd0);
        step();
        repeat (3) step();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("t4_stop_wins", 32'(busy), 32'd0);
        step();
        check("t4_stop_wins2", 32'(busy), 32'd0);

        // 5: period 0 acts as 1; restart mid-RUN with period 4.
        $display("[TB] period=0 and restart");
        do_reset();
        do_start(1'b0, 17'd0, 8'd0);
        step();
        step();
        check("t5_p0_irq", 32'(irq), 32'd1);
        check("t5_p0_busy", 32'(busy), 32'd0);
        check("t5_p0_exp", 32'(expire_cnt), 32'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        do_start(1'b1, 17'd10, 8'd1);
        step();
        repeat (3) step();
        check("t5_mid_cnt", 32'(cnt_reg), 32'd1);
        do_start(1'b1, 17'd4, 8'd0);
        check("t5_restart_cnt", 32'(cnt_reg), 32'd0);
        check("t5_restart_busy", 32'(busy), 32'd1);
        step();
        repeat (3) step();
        check("t5_pre_exp", 32'(expire_cnt), 32'd1);
        check("t5_pre_cnt", 32'(cnt_reg), 32'd3);
        step();
        check("t5_exp", 32'(expire_cnt), 32'd2);
        check("t5_irq", 32'(irq), 32'd1);
        check("t5_cnt", 32'(cnt_reg), 32'd0);

        // 6: clr for one cycle mid-RUN.
        $display("[TB] clr mid-RUN");
        do_reset();
        do_start(1'b1, 17'd3, 8'd0);
        step();
        repeat (5) step();
        check("t6_exp_before", 32'(expire_cnt), 32'd1);
        check("t6_cnt_before", 32'(cnt_reg), 32'd2);
        clr = 1'b1;
        #1;
        check("t6_clr_comb", 32'(cnt_clr), 32'd1);
        check("t6_en_comb", 32'(cnt_en), 32'd0);
        check("t6_busy_comb", 32'(busy), 32'd0);
        step();
        clr = 1'b0;
        #1;
        check("t6_irq", 32'(irq), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_exp", 32'(expire_cnt), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cnt", 32'(cnt_reg), 32'd0);
        check("t6_idle_clr", 32'(cnt_clr), 32'd1);
        step();
        check("t6_stay_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_timer_ctrl
